// File: rtl/oets_sorter.sv
// Iterative odd-even transposition sorter: N/2 shared compare-and-swap units reorder a
// registered array into descending order over N phases behind a start/done handshake.

module cas #(
    parameter int unsigned BITS = 10
) (
    input  logic [BITS-1:0] a_i,
    input  logic [BITS-1:0] b_i,
    output logic [BITS-1:0] a_new_o,
    output logic [BITS-1:0] b_new_o
);
    assign a_new_o = (a_i >= b_i) ? a_i : b_i;
    assign b_new_o = (a_i >= b_i) ? b_i : a_i;
endmodule

module oets_sorter #(
    parameter int unsigned BITS = 10,
    parameter int unsigned N    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [N*BITS-1:0] din_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N*BITS-1:0] dout_o
);
    localparam int unsigned PhW = (N > 2) ? $clog2(N) : 1;
    localparam int unsigned NCas = N / 2;

    typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

    state_e           state_q, state_d;
    logic [PhW-1:0]   ph_q, ph_d;
    logic [BITS-1:0]  r_q [N];
    logic [BITS-1:0]  r_d [N];
    logic [BITS-1:0]  cas_a  [NCas];
    logic [BITS-1:0]  cas_b  [NCas];
    logic [BITS-1:0]  cas_hi [NCas];
    logic [BITS-1:0]  cas_lo [NCas];

    // Unit k serves pair (2k,2k+1) on even phases and (2k+1,2k+2) on odd ones; the last
    // unit has no odd-phase pair and its result is discarded then.
    for (genvar k = 0; k < NCas; k++) begin : g_cas
        if (2 * k + 2 < N) begin : g_shared
            assign cas_a[k] = ph_q[0] ? r_q[2*k+1] : r_q[2*k];
            assign cas_b[k] = ph_q[0] ? r_q[2*k+2] : r_q[2*k+1];
        end else begin : g_even_only
            assign cas_a[k] = r_q[2*k];
            assign cas_b[k] = r_q[2*k+1];
        end

        cas #(
            .BITS(BITS)
        ) u_cas (
            .a_i     (cas_a[k]),
            .b_i     (cas_b[k]),
            .a_new_o (cas_hi[k]),
            .b_new_o (cas_lo[k])
        );
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        r_d     = r_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    for (int i = 0; i < N; i++) begin
                        r_d[i] = din_i[i*BITS +: BITS];
                    end
                    ph_d    = '0;
                    state_d = StSort;
                end
            end
            StSort: begin
                if (!ph_q[0]) begin
                    for (int k = 0; k < NCas; k++) begin
                        r_d[2*k]   = cas_hi[k];
                        r_d[2*k+1] = cas_lo[k];
                    end
                end else begin
                    for (int k = 0; k < NCas - 1; k++) begin
                        r_d[2*k+1] = cas_hi[k];
                        r_d[2*k+2] = cas_lo[k];
                    end
                end
                ph_d = ph_q + 1'b1;
                if (ph_q == PhW'(N - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ph_q    <= '0;
            for (int i = 0; i < N; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        dout_o = '0;
        for (int i = 0; i < N; i++) begin
            dout_o[i*BITS +: BITS] = r_q[i];
        end
    end

    assign busy_o = (state_q == StSort);
    assign done_o = (state_q == StDone);
endmodule

// File: tb/tb_oets_sorter.sv
// Directed and random bench for oets_sorter with a reference descending sort.

module tb_oets_sorter;
    localparam int unsigned BITS = 10;
    localparam int unsigned N    = 4;
    localparam int unsigned W    = N * BITS;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] din = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    oets_sorter #(
        .BITS(BITS),
        .N   (N)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .din_i   (din),
        .busy_o  (busy),
        .done_o  (done),
        .dout_o  (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input int e0, input int e1, input int e2, input int e3);
        logic [W-1:0] p;
        p = {BITS'(e3), BITS'(e2), BITS'(e1), BITS'(e0)};
        return p;
    endfunction

    function automatic logic [W-1:0] ref_sort(input logic [W-1:0] v);
        logic [BITS-1:0] e [N];
        logic [BITS-1:0] t;
        logic [W-1:0]    p;
        for (int i = 0; i < N; i++) e[i] = v[i*BITS +: BITS];
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N - 1 - i; j++) begin
                if (e[j] < e[j+1]) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
            end
        end
        p = '0;
        for (int i = 0; i < N; i++) p[i*BITS +: BITS] = e[i];
        return p;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Raises start before edge 0, returns result and number of edges until done is seen.
    task automatic run_sort(input logic [W-1:0] d, output logic [W-1:0] res, output int lat);
        @(negedge clk);
        din   = d;
        start = 1'b1;
        lat   = 0;
        @(negedge clk);
        lat   = 1;
        start = 1'b0;
        chk("busy_after_accept", W'(busy), W'(1));
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = dout;
    endtask

    logic [W-1:0] res;
    logic [W-1:0] cap;
    int           lat;
    int           ndone;
    int           wait_cnt;

    initial begin
        vecs[0] = '{pack(3, 1000, 0, 512),     pack(1000, 512, 3, 0)};
        vecs[1] = '{pack(0, 1, 2, 1023),       pack(1023, 2, 1, 0)};
        vecs[2] = '{pack(1023, 700, 5, 0),     pack(1023, 700, 5, 0)};
        vecs[3] = '{pack(511, 511, 511, 511),  pack(511, 511, 511, 511)};
        vecs[4] = '{pack(5, 5, 1, 9),          pack(9, 5, 5, 1)};
        vecs[5] = '{pack(1023, 0, 1023, 0),    pack(1023, 1023, 0, 0)};

        // Put something in r first so the asynchronous reset has visible work to do.
        rst = 1'b1;
        #12 rst = 1'b0;
        run_sort(vecs[0].din, res, lat);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_busy", W'(busy), W'(0));
        chk("async_rst_done", W'(done), W'(0));
        chk("async_rst_dout", dout, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_rst_busy", W'(busy), W'(0));
        chk("idle_after_rst_dout", dout, '0);

        foreach (vecs[i]) begin
            run_sort(vecs[i].din, res, lat);
            chk($sformatf("latency_%0d", i), W'(lat), W'(N + 1));
            chk($sformatf("dout_%0d", i), res, vecs[i].exp);
            @(negedge clk);
            chk($sformatf("done_pulse_%0d", i), W'(done), W'(0));
            chk($sformatf("busy_idle_%0d", i), W'(busy), W'(0));
            repeat (2) @(negedge clk);
            chk($sformatf("dout_hold_%0d", i), dout, vecs[i].exp);
        end

        // Second start while busy must be ignored.
        @(negedge clk);
        din   = pack(7, 300, 900, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        din   = pack(1, 2, 3, 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        res   = '0;
        repeat (12) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                res = dout;
            end
        end
        chk("busy_ignore_ndone", W'(ndone), W'(1));
        chk("busy_ignore_dout", res, pack(900, 300, 7, 2));

        // Reset after edge 2 of a sort aborts it.
        @(negedge clk);
        din   = pack(10, 20, 30, 40);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midsort_rst_busy", W'(busy), W'(0));
        chk("midsort_rst_dout", dout, '0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midsort_rst_nodone", W'(ndone), W'(0));
        rst = 1'b0;
        run_sort(pack(10, 20, 30, 40), res, lat);
        chk("after_rst_latency", W'(lat), W'(N + 1));
        chk("after_rst_dout", res, pack(40, 30, 20, 10));
        @(negedge clk);

        // Back-to-back random sorts with start held high.
        @(negedge clk);
        din   = W'({$urandom, $urandom});
        cap   = din;
        start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            wait_cnt = 0;
            @(negedge clk);
            while (!done && wait_cnt < 20) begin
                @(negedge clk);
                wait_cnt++;
            end
            chk("rand_timeout", W'(done), W'(1));
            chk($sformatf("rand_%0d", n), dout, ref_sort(cap));
            din = W'({$urandom, $urandom});
            cap = din;
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
